// File: rtl/keypad_scan_controller.sv
// ---------------------------------------------------------------------------
// keypad_scan_controller
//
// Scans a 4x4 active-low matrix keypad one row at a time, debounces each of
// the 16 keys across scan frames and queues every debounced press into a
// small event FIFO with a valid/ready interface.
//
// Ports:
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   col_in     in   4   keypad columns, pulled up, active low, asynchronous
//   row_out    out  4   keypad rows, active low, one row low while scanning
//   key_valid  out  1   event FIFO non-empty, key_code is valid
//   key_code   out  4   head event, code = row*4 + col
//   key_ready  in   1   consumer accepts the head event when key_valid is high
//   key_state  out 16   debounced level per key, bit row*4+col, 1 = pressed
//   overflow   out  1   one-cycle pulse when a press is dropped (FIFO full)
//   frame_done out  1   one-cycle pulse when row 3 wraps back to row 0
// ---------------------------------------------------------------------------
module keypad_scan_controller #(
   parameter int ROW_CYCLES     = 25000,
   parameter int SETTLE_CYCLES  = 250,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  col_in,
   output logic [3:0]  row_out,
   output logic        key_valid,
   output logic [3:0]  key_code,
   input  logic        key_ready,
   output logic [15:0] key_state,
   output logic        overflow,
   output logic        frame_done
);

   localparam int CNT_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ROW_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_EMIT0  = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_EMIT3  = CNT_W'(SETTLE_CYCLES + 3);
   localparam logic [4:0]       DEB_N      = 5'(DEBOUNCE_SCANS);

   // Column synchronizer
   logic [3:0]        sync1_q, sync2_q;

   // Row sequencer
   logic [CNT_W-1:0]  row_cnt_q, row_cnt_d;
   logic [1:0]        row_q, row_d;
   logic [3:0]        row_out_q, row_out_d;
   logic              frame_done_q, frame_done_d;

   // Debounce and press detection
   logic [15:0]       key_state_q, key_state_d;
   logic [15:0][3:0]  deb_cnt_q, deb_cnt_d;
   logic [3:0]        pending_q, pending_d;

   // Emit
   logic [1:0]        emit_col;
   logic              push_req;
   logic [3:0]        push_code;

   // Event FIFO
   logic [3:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
   logic              fifo_empty, fifo_full;
   logic              push, pop;
   logic              overflow_q, overflow_d;

   // -----------------------------------------------------------------------
   // Row sequencing: row_out is registered so it changes on the same edge as
   // row_q and never passes through 1111 between rows.
   // -----------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first so no path through this block
      // leaves it unassigned, which would otherwise infer a latch.
      row_cnt_d    = row_cnt_q + CNT_W'(1);
      row_d        = row_q;
      frame_done_d = 1'b0;
      if (row_cnt_q == CNT_LAST) begin
         row_cnt_d    = '0;
         row_d        = row_q + 2'd1;
         frame_done_d = (row_q == 2'd3);
      end
      row_out_d = ~(4'b0001 << row_d);
   end

   // -----------------------------------------------------------------------
   // Debounce: one sample per key per frame, taken just before the emit
   // window of the current row. A rising toggle marks the column pending.
   // -----------------------------------------------------------------------
   always_comb begin
      key_state_d = key_state_q;
      deb_cnt_d   = deb_cnt_q;
      pending_d   = pending_q;
      if (row_cnt_q == CNT_EMIT3) begin
         pending_d = '0;
      end
      if (row_cnt_q == CNT_SAMPLE) begin
         for (int c = 0; c < 4; c++) begin
            if (~sync2_q[c] == key_state_q[{row_q, 2'(c)}]) begin
               deb_cnt_d[{row_q, 2'(c)}] = '0;
            end else if (({1'b0, deb_cnt_q[{row_q, 2'(c)}]} + 5'd1) == DEB_N) begin
               key_state_d[{row_q, 2'(c)}] = ~sync2_q[c];
               deb_cnt_d[{row_q, 2'(c)}]   = '0;
               if (~sync2_q[c]) begin
                  pending_d[c] = 1'b1;
               end
            end else begin
               deb_cnt_d[{row_q, 2'(c)}] = deb_cnt_q[{row_q, 2'(c)}] + 4'd1;
            end
         end
      end
   end

   // -----------------------------------------------------------------------
   // Emit window: one column per cycle in ascending order, so at most one
   // push per cycle reaches the FIFO.
   // -----------------------------------------------------------------------
   always_comb begin
      emit_col  = 2'(row_cnt_q - CNT_EMIT0);
      push_req  = 1'b0;
      push_code = 4'd0;
      if ((row_cnt_q >= CNT_EMIT0) && (row_cnt_q <= CNT_EMIT3) && pending_q[emit_col]) begin
         push_req  = 1'b1;
         push_code = {row_q, emit_col};
      end
   end

   // -----------------------------------------------------------------------
   // Event FIFO. Pointers carry one extra wrap bit to tell full from empty.
   // A push into a full FIFO is accepted when the head pops in the same
   // cycle: the write lands in the slot being vacated.
   // -----------------------------------------------------------------------
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop        = !fifo_empty && key_ready;
   assign push       = push_req && (!fifo_full || pop);
   assign overflow_d = push_req && fifo_full && !pop;
   assign wr_ptr_d   = wr_ptr_q + {{PTR_W{1'b0}}, push};
   assign rd_ptr_d   = rd_ptr_q + {{PTR_W{1'b0}}, pop};

   // NOTE: the storage array has no reset; an entry is only ever read after
   // it has been written, and key_code is forced to 0 while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_code;
      end
   end

   // NOTE: all state updates use non-blocking assignments so every flop
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 4'b1111;
         sync2_q      <= 4'b1111;
         row_cnt_q    <= '0;
         row_q        <= 2'd0;
         row_out_q    <= 4'b1111;
         frame_done_q <= 1'b0;
         key_state_q  <= '0;
         deb_cnt_q    <= '0;
         pending_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overflow_q   <= 1'b0;
      end else begin
         sync1_q      <= col_in;
         sync2_q      <= sync1_q;
         row_cnt_q    <= row_cnt_d;
         row_q        <= row_d;
         row_out_q    <= row_out_d;
         frame_done_q <= frame_done_d;
         key_state_q  <= key_state_d;
         deb_cnt_q    <= deb_cnt_d;
         pending_q    <= pending_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overflow_q   <= overflow_d;
      end
   end

   assign row_out    = row_out_q;
   assign frame_done = frame_done_q;
   assign key_state  = key_state_q;
   assign overflow   = overflow_q;
   assign key_valid  = !fifo_empty;
   assign key_code   = fifo_empty ? 4'd0 : fifo_mem[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: tb/tb_keypad_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_controller
//
// Directed bench for keypad_scan_controller with a 128-cycle frame
// (32 cycles per row, sample at row cycle 7, emit at row cycles 8..11).
// Stimulus pushes expected key codes into a queue; a separate monitor pops
// and compares whenever the DUT hands over an event. A behavioural keypad
// pulls a column low when its row is driven and the key is held.
// ---------------------------------------------------------------------------
module tb_keypad_scan_controller;

   localparam int ROW_CYCLES     = 32;
   localparam int SETTLE_CYCLES  = 8;
   localparam int DEBOUNCE_SCANS = 3;
   localparam int FIFO_DEPTH     = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_ready = 1'b1;
   logic [15:0] key_state;
   logic        overflow;
   logic        frame_done;

   logic [15:0] pressed = '0;
   logic [3:0]  exp_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   keypad_scan_controller #(
      .ROW_CYCLES     (ROW_CYCLES),
      .SETTLE_CYCLES  (SETTLE_CYCLES),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
      .FIFO_DEPTH     (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .col_in     (col_in),
      .row_out    (row_out),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_ready  (key_ready),
      .key_state  (key_state),
      .overflow   (overflow),
      .frame_done (frame_done)
   );

   // Keypad matrix model
   always_comb begin
      col_in = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic skip(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns on the negedge of the first cycle of a frame (frame index 0).
   task automatic wait_frame();
      int n = 0;
      @(negedge clk);
      while (!frame_done && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("wait_frame", frame_done, 1);
   endtask

   // Scoreboard monitor: looks just after the negedge, when key_ready for the
   // coming edge is settled.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && key_valid && key_ready) begin
            check("event_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("event_code", key_code, exp_q.pop_front());
         end
      end
   end

   initial begin
      int          bad;
      int          fd_bad;
      logic [3:0]  exp_row;

      // ---- 1. reset mid-scan and row sequencing ----
      skip(3);
      rst_n = 1'b1;
      skip(50);
      rst_n = 1'b0;
      #2;
      check("rst_row_out", row_out, 4'b1111);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_code", key_code, 0);
      check("rst_key_state", key_state, 0);
      check("rst_overflow", overflow, 0);
      check("rst_frame_done", frame_done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      wait_frame();
      fd_bad = 0;
      for (int seg = 0; seg < 4; seg++) begin
         bad = 0;
         exp_row = ~(4'b0001 << seg);
         for (int i = 0; i < 32; i++) begin
            if (row_out !== exp_row) bad++;
            if (frame_done !== (seg == 0 && i == 0)) fd_bad++;
            skip(1);
         end
         check($sformatf("row_seg%0d_bad_cycles", seg), bad, 0);
      end
      check("frame_done_spurious", fd_bad, 0);
      check("frame_done_period", frame_done, 1);
      check("row_wrap_to_0", row_out, 4'b1110);

      // ---- 2. press and release key 6 ----
      wait_frame();
      pressed[6] = 1'b1;
      exp_q.push_back(4'd6);
      skip(295);
      check("t2_state_before_3rd", key_state[6], 0);
      skip(1);
      check("t2_state_after_3rd", key_state[6], 1);
      skip(2);
      check("t2_valid_on_emit", key_valid, 0);
      skip(1);
      check("t2_valid_latency", key_valid, 1);
      check("t2_code", key_code, 4'd6);
      pressed[6] = 1'b0;
      skip(380);
      check("t2_release_before", key_state[6], 1);
      skip(1);
      check("t2_release_after", key_state, 16'h0000);

      // ---- 3. glitches: 2-frame presses never debounce ----
      wait_frame();
      pressed[6] = 1'b1;
      skip(256);
      pressed[6] = 1'b0;
      skip(128);
      pressed[6] = 1'b1;
      skip(256);
      pressed[6] = 1'b0;
      skip(40);
      check("t3_glitch_state", key_state, 16'h0000);

      // ---- 4. two keys in row 0 ----
      wait_frame();
      key_ready = 1'b0;
      pressed = 16'h000A;
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd3);
      skip(266);
      check("t4_first_valid", key_valid, 1);
      check("t4_first_code", key_code, 4'd1);
      skip(2);
      check("t4_head_stable", key_code, 4'd1);
      key_ready = 1'b1;
      skip(1);
      check("t4_second_code", key_code, 4'd3);
      check("t4_second_valid", key_valid, 1);
      skip(1);
      check("t4_drained", key_valid, 0);
      check("t4_state", key_state, 16'h000A);
      pressed = '0;
      skip(512);

      // ---- 5. overflow on the 5th press ----
      wait_frame();
      key_ready = 1'b0;
      pressed = 16'h8431;
      exp_q.push_back(4'd0);
      exp_q.push_back(4'd4);
      exp_q.push_back(4'd5);
      exp_q.push_back(4'd10);
      skip(363);
      check("t5_ovf_before", overflow, 0);
      check("t5_head_before", key_code, 4'd0);
      skip(1);
      check("t5_ovf_pulse", overflow, 1);
      skip(1);
      check("t5_ovf_one_cycle", overflow, 0);
      check("t5_head_after", key_code, 4'd0);
      check("t5_valid_full", key_valid, 1);
      key_ready = 1'b1;
      skip(4);
      check("t5_drained", key_valid, 0);
      check("t5_state", key_state, 16'h8431);
      pressed = '0;
      skip(512);

      // ---- 6. push into full FIFO with simultaneous pop ----
      wait_frame();
      key_ready = 1'b0;
      pressed = 16'h001F;
      for (int k = 0; k < 5; k++) exp_q.push_back(4'(k));
      skip(296);
      check("t6_full_valid", key_valid, 1);
      check("t6_full_head", key_code, 4'd0);
      key_ready = 1'b1;
      skip(1);
      key_ready = 1'b0;
      check("t6_no_overflow", overflow, 0);
      check("t6_new_head", key_code, 4'd1);
      skip(1);
      check("t6_no_overflow_late", overflow, 0);
      key_ready = 1'b1;
      skip(4);
      check("t6_drained", key_valid, 0);
      pressed = '0;
      skip(512);

      // ---- 7. reset with a queued event and a held key ----
      wait_frame();
      key_ready = 1'b0;
      pressed[7] = 1'b1;
      skip(300);
      check("t7_queued_valid", key_valid, 1);
      check("t7_queued_code", key_code, 4'd7);
      check("t7_state_set", key_state[7], 1);
      rst_n = 1'b0;
      #2;
      check("t7_rst_row_out", row_out, 4'b1111);
      check("t7_rst_valid", key_valid, 0);
      check("t7_rst_code", key_code, 0);
      check("t7_rst_state", key_state, 0);
      pressed = '0;
      @(negedge clk);
      rst_n = 1'b1;
      key_ready = 1'b1;
      skip(300);
      check("t7_no_event_after_rst", key_valid, 0);
      check("t7_state_after_rst", key_state, 0);

      check("scoreboard_left", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
